// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the next-PC / hazard controller.
package npc_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INC    = 4;
    localparam logic [4:0]  REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        MEM_STALL = 2'd2
    } state_e;

endpackage

// File: rtl/npc_ctrl_if.sv
// Pipeline-side bus of npc_ctrl; perf counter signals exist only with NPC_CTRL_PERF_EN.
interface npc_ctrl_if #(
    parameter int unsigned XLEN = npc_ctrl_pkg::XLEN
);
    logic [XLEN-1:0] pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [4:0]      ex_rd;
    logic            ex_memread;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_target;
    logic            dmem_busy;
    logic [XLEN-1:0] npc;
    logic            pc_write_en;
    logic            ifid_write_en;
    logic            ifid_flush;
    logic            idex_flush;
`ifdef NPC_CTRL_PERF_EN
    logic [31:0]     perf_lu_stalls;
    logic [31:0]     perf_mem_stalls;
    logic [31:0]     perf_redirects;

    modport master (
        output pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, ex_target, dmem_busy,
        input  npc, pc_write_en, ifid_write_en, ifid_flush, idex_flush,
               perf_lu_stalls, perf_mem_stalls, perf_redirects
    );
    modport slave (
        input  pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, ex_target, dmem_busy,
        output npc, pc_write_en, ifid_write_en, ifid_flush, idex_flush,
               perf_lu_stalls, perf_mem_stalls, perf_redirects
    );
`else
    modport master (
        output pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, ex_target, dmem_busy,
        input  npc, pc_write_en, ifid_write_en, ifid_flush, idex_flush
    );
    modport slave (
        input  pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, ex_target, dmem_busy,
        output npc, pc_write_en, ifid_write_en, ifid_flush, idex_flush
    );
`endif
endinterface

// File: rtl/npc_ctrl_hazard_detect.sv
// Combinational load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect
    import npc_ctrl_pkg::*;
(
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    output logic       o_lu
);
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2 = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_lu      = i_ex_memread && (i_ex_rd != REG_X0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC and hazard controller: arbitrates sequential fetch, EX redirects, load-use and
// data-memory stalls. Optional perf counters are built when NPC_CTRL_PERF_EN is defined.
module npc_ctrl #(
    parameter int unsigned XLEN = npc_ctrl_pkg::XLEN,
    parameter int unsigned INC  = npc_ctrl_pkg::INC
) (
    input logic       clk,
    input logic       rst,
    npc_ctrl_if.slave bus
);
    import npc_ctrl_pkg::*;

    state_e          r_state;
    state_e          w_state_d;
    logic            r_pend_valid;
    logic            w_pend_valid_d;
    logic [XLEN-1:0] r_pend_target;
    logic [XLEN-1:0] w_pend_target_d;

    logic            w_lu;
    logic [XLEN-1:0] w_npc;
    logic            w_pc_we;
    logic            w_ifid_we;
    logic            w_ifid_flush;
    logic            w_idex_flush;
    logic            w_ev_lu;
    logic            w_ev_mem;
    logic            w_ev_redir;

    hazard_detect u_hazard_detect (
        .i_ex_memread (bus.ex_memread),
        .i_ex_rd      (bus.ex_rd),
        .i_id_rs1     (bus.id_rs1),
        .i_id_rs2     (bus.id_rs2),
        .i_id_use_rs1 (bus.id_use_rs1),
        .i_id_use_rs2 (bus.id_use_rs2),
        .o_lu         (w_lu)
    );

    always_comb begin
        w_npc           = bus.pc + XLEN'(INC);
        w_pc_we         = 1'b1;
        w_ifid_we       = 1'b1;
        w_ifid_flush    = 1'b0;
        w_idex_flush    = 1'b0;
        w_state_d       = RUN;
        w_pend_valid_d  = r_pend_valid;
        w_pend_target_d = r_pend_target;
        w_ev_lu         = 1'b0;
        w_ev_mem        = 1'b0;
        w_ev_redir      = 1'b0;

        if (rst) begin
            w_npc        = bus.pc;
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (bus.dmem_busy) begin
            w_npc     = bus.pc;
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_state_d = MEM_STALL;
            w_ev_mem  = 1'b1;
            if (bus.ex_redirect) begin
                w_pend_valid_d  = 1'b1;
                w_pend_target_d = bus.ex_target;
            end
        end else if (bus.ex_redirect || r_pend_valid) begin
            w_npc          = bus.ex_redirect ? bus.ex_target : r_pend_target;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_pend_valid_d = 1'b0;
            w_ev_redir     = 1'b1;
        end else if (w_lu && (r_state != LU_STALL)) begin
            // A load frozen in EX by a memory stall still gets its bubble on MEM_STALL exit.
            w_npc        = bus.pc;
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
            w_state_d    = LU_STALL;
            w_ev_lu      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pend_valid  <= w_pend_valid_d;
            r_pend_target <= w_pend_target_d;
        end
    end

    assign bus.npc           = w_npc;
    assign bus.pc_write_en   = w_pc_we;
    assign bus.ifid_write_en = w_ifid_we;
    assign bus.ifid_flush    = w_ifid_flush;
    assign bus.idex_flush    = w_idex_flush;

`ifdef NPC_CTRL_PERF_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_lu    <= '0;
            r_perf_mem   <= '0;
            r_perf_redir <= '0;
        end else begin
            if (w_ev_lu && (r_perf_lu != '1)) r_perf_lu <= r_perf_lu + 32'd1;
            if (w_ev_mem && (r_perf_mem != '1)) r_perf_mem <= r_perf_mem + 32'd1;
            if (w_ev_redir && (r_perf_redir != '1)) r_perf_redir <= r_perf_redir + 32'd1;
        end
    end

    assign bus.perf_lu_stalls  = r_perf_lu;
    assign bus.perf_mem_stalls = r_perf_mem;
    assign bus.perf_redirects  = r_perf_redir;
`else
    logic w_unused_ev;
    assign w_unused_ev = w_ev_lu ^ w_ev_mem ^ w_ev_redir;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboard bench for npc_ctrl: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_npc_ctrl;
    logic clk;
    logic rst;

    npc_ctrl_if #(.XLEN(32)) bus ();

    npc_ctrl #(.XLEN(32), .INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic        pc_we;
        logic        ifid_we;
        logic        ifid_fl;
        logic        idex_fl;
        logic        chk_perf;
        logic [31:0] p_lu;
        logic [31:0] p_mem;
        logic [31:0] p_red;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    logic        want_perf = 1'b0;
    logic [31:0] want_lu   = '0;
    logic [31:0] want_mem  = '0;
    logic [31:0] want_red  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.npc !== e.npc || bus.pc_write_en !== e.pc_we ||
                bus.ifid_write_en !== e.ifid_we || bus.ifid_flush !== e.ifid_fl ||
                bus.idex_flush !== e.idex_fl) begin
                errors++;
                $display("FAIL %s: got npc=%h pcwe=%b ifidwe=%b ifidfl=%b idexfl=%b, want npc=%h pcwe=%b ifidwe=%b ifidfl=%b idexfl=%b",
                         e.name, bus.npc, bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush,
                         bus.idex_flush, e.npc, e.pc_we, e.ifid_we, e.ifid_fl, e.idex_fl);
            end
`ifdef NPC_CTRL_PERF_EN
            if (e.chk_perf) begin
                checks++;
                if (bus.perf_lu_stalls !== e.p_lu || bus.perf_mem_stalls !== e.p_mem ||
                    bus.perf_redirects !== e.p_red) begin
                    errors++;
                    $display("FAIL %s_perf: got lu=%0d mem=%0d red=%0d, want lu=%0d mem=%0d red=%0d",
                             e.name, bus.perf_lu_stalls, bus.perf_mem_stalls, bus.perf_redirects,
                             e.p_lu, e.p_mem, e.p_red);
                end
            end
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_use_rs1  = 1'b0;
        bus.id_use_rs2  = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.ex_memread  = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = 32'd0;
        bus.dmem_busy   = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] npc, input logic pwe,
                              input logic iwe, input logic ifl, input logic xfl);
        exp_t x;
        x.name     = nm;
        x.npc      = npc;
        x.pc_we    = pwe;
        x.ifid_we  = iwe;
        x.ifid_fl  = ifl;
        x.idex_fl  = xfl;
        x.chk_perf = want_perf;
        x.p_lu     = want_lu;
        x.p_mem    = want_mem;
        x.p_red    = want_red;
        want_perf  = 1'b0;
        q.push_back(x);
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        bus.pc = 32'h100;

        cyc(); expect_out("reset", 32'h100, 0, 0, 1, 1);

        // Reset asserted in the middle of a memory stall with a redirect pending
        cyc(); rst = 1'b0; bus.dmem_busy = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 32'h500;
        expect_out("busy_pend", 32'h100, 0, 0, 0, 0);
        cyc(); bus.ex_redirect = 1'b0; rst = 1'b1;
        expect_out("reset_mid_stall", 32'h100, 0, 0, 1, 1);
        cyc(); rst = 1'b0; bus.dmem_busy = 1'b0;
        expect_out("after_reset", 32'h104, 1, 1, 0, 0);

        cyc(); bus.pc = 32'h2000;
        expect_out("seq", 32'h2004, 1, 1, 0, 0);

        // Load-use on rs1: one bubble, then suppressed for a cycle
        cyc(); bus.pc = 32'h300; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        expect_out("lu_stall", 32'h300, 0, 0, 0, 1);
        cyc(); expect_out("lu_suppress", 32'h304, 1, 1, 0, 0);
        cyc(); clear_in(); bus.pc = 32'h304;
        expect_out("lu_after", 32'h308, 1, 1, 0, 0);

        cyc(); bus.pc = 32'h308; bus.ex_memread = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
        expect_out("lu_x0", 32'h30C, 1, 1, 0, 0);

        cyc(); bus.pc = 32'h30C; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd1;
        bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b0;
        expect_out("rs2_unused", 32'h310, 1, 1, 0, 0);
        cyc(); bus.id_use_rs2 = 1'b1;
        expect_out("lu_rs2", 32'h30C, 0, 0, 0, 1);
        cyc(); clear_in(); bus.pc = 32'h310;
        expect_out("lu_rs2_after", 32'h314, 1, 1, 0, 0);

        // Redirect beats a concurrent load-use hazard
        cyc(); bus.pc = 32'h400; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        bus.ex_redirect = 1'b1; bus.ex_target = 32'h200;
        expect_out("redir_lu", 32'h200, 1, 1, 1, 1);
        cyc(); clear_in(); bus.pc = 32'h200;
        expect_out("redir_after", 32'h204, 1, 1, 0, 0);

        // Three busy cycles with a redirect in the second
        cyc(); bus.pc = 32'h600; bus.dmem_busy = 1'b1;
        expect_out("busy1", 32'h600, 0, 0, 0, 0);
        cyc(); bus.ex_redirect = 1'b1; bus.ex_target = 32'h340;
        expect_out("busy2", 32'h600, 0, 0, 0, 0);
        cyc(); bus.ex_redirect = 1'b0;
        expect_out("busy3", 32'h600, 0, 0, 0, 0);
        cyc(); bus.dmem_busy = 1'b0;
        expect_out("pend_apply", 32'h340, 1, 1, 1, 1);
        cyc(); bus.pc = 32'h340;
        want_perf = 1'b1; want_lu = 32'd2; want_mem = 32'd3; want_red = 32'd2;
        expect_out("pend_cleared", 32'h344, 1, 1, 0, 0);

        // Second redirect during a stall overwrites the first
        cyc(); bus.pc = 32'h344; bus.dmem_busy = 1'b1; bus.ex_redirect = 1'b1;
        bus.ex_target = 32'h700;
        expect_out("latest_busy1", 32'h344, 0, 0, 0, 0);
        cyc(); bus.ex_target = 32'h800;
        expect_out("latest_busy2", 32'h344, 0, 0, 0, 0);
        cyc(); clear_in();
        expect_out("latest_wins", 32'h800, 1, 1, 1, 1);
        cyc(); bus.pc = 32'h800;
        expect_out("latest_after", 32'h804, 1, 1, 0, 0);

        // Live redirect takes precedence over a pending one
        cyc(); bus.dmem_busy = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 32'h900;
        expect_out("prec_busy", 32'h800, 0, 0, 0, 0);
        cyc(); bus.dmem_busy = 1'b0; bus.ex_target = 32'hA00;
        expect_out("prec_live", 32'hA00, 1, 1, 1, 1);
        cyc(); clear_in(); bus.pc = 32'hA00;
        expect_out("prec_after", 32'hA04, 1, 1, 0, 0);

        cyc(); bus.pc = 32'hFFFF_FFFC;
        expect_out("wrap", 32'h0, 1, 1, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_ctrl.md
# npc_ctrl

Next-PC and pipeline-hazard controller for the five-stage RV32 pipeline. It drives the `NPC` value and `write_enable` of the PC register, and the stall/flush controls of the IF/ID and ID/EX pipeline registers. Sources it arbitrates:
- sequential fetch
- EX-stage branch/jump redirects
- load-use stalls
- multi-cycle data-memory busy stalls

Redirects that arrive during a memory stall are held until the stall releases.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `INC`, 4: sequential PC increment.

Ports:
- `clk`  in  1  clock; internal state updates on posedge, outputs settle before the PC register's negedge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  XLEN  current PC register value.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  the instruction in ID actually reads that source.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_memread`  in  1  the instruction in EX is a load.
- `ex_redirect`  in  1  single-cycle pulse: taken branch, JAL or JALR resolved in EX.
- `ex_target`  in  XLEN  redirect target; valid with `ex_redirect`.
- `dmem_busy`  in  1  data memory is not ready; the whole pipeline freezes.
- `npc`  out  XLEN  next PC, fed to the PC register.
- `pc_write_en`  out  1  PC register write enable.
- `ifid_write_en`  out  1  IF/ID register write enable.
- `ifid_flush`, `idex_flush`  out  1  insert a bubble into that register.

## Operation
- States: RUN, LU_STALL, MEM_STALL.
- Pending registers: `pend_valid`, `pend_target`.
- Load-use hazard (`lu`) is true when all of the following hold:
  - `ex_memread`
  - `ex_rd != 0`
  - (`id_use_rs1` and `id_rs1 == ex_rd`) or (`id_use_rs2` and `id_rs2 == ex_rd`)
- Output priority, highest first:
  1. `rst`: `pc_write_en=0`, `ifid_write_en=0`, `ifid_flush=1`, `idex_flush=1`, `npc=pc`.
  2. `dmem_busy`: all enables 0, all flushes 0, `npc=pc`. If `ex_redirect` is high, latch `pend_valid=1` and `pend_target=ex_target`. Next state is MEM_STALL.
  3. Redirect active (`ex_redirect`, or `pend_valid` while not busy): `npc` = target, with `ex_redirect` taking precedence over pending. `pc_write_en=1`, `ifid_write_en=1`, `ifid_flush=1`, `idex_flush=1`. Clear `pend_valid`. Next state is RUN. The redirect overrides `lu`, because the dependent instruction is squashed.
  4. `lu` in state RUN: `pc_write_en=0`, `ifid_write_en=0`, `idex_flush=1`, `ifid_flush=0`, `npc=pc`. Next state is LU_STALL.
  5. Otherwise: `npc = pc + INC` (mod 2^XLEN), both enables 1, both flushes 0, next state RUN.
- LU_STALL suppresses `lu` for exactly one cycle, guaranteeing a single bubble per load. It then returns to RUN.
- MEM_STALL is left on the first cycle with `dmem_busy=0`. That cycle is evaluated at priority 3 or lower.
- A second redirect while one is pending overwrites `pend_target` (latest wins).
- Reset clears the state to RUN, `pend_valid` to 0 and `pend_target` to 0, including when reset is asserted mid-stall.

## Timing
- Combinational latency from inputs to outputs is 0 cycles.
- Redirect penalty is 2 bubbles: IF/ID and ID/EX are flushed in the same cycle.
- A load-use stall costs exactly 1 cycle.
- A pending redirect is applied on the first non-busy cycle after `dmem_busy` falls.
- PC wrap at `32'hFFFF_FFFC + 4` yields 0.

## Configuration
- `NPC_CTRL_PERF_EN` defined adds three 32-bit saturating counter outputs:
  - `perf_lu_stalls`: counts cycles at priority 4.
  - `perf_mem_stalls`: counts `dmem_busy` cycles.
  - `perf_redirects`: counts redirects applied.
- The counters reset to 0 and hold at `32'hFFFF_FFFF`.
- Undefined: the counter ports and logic are absent, and all other behaviour is identical.

## Structure
- The shared package holds:
  - the state enum (RUN, LU_STALL, MEM_STALL)
  - `XLEN`
  - the `INC` constant
  - the `REG_X0 = 5'd0` constant
- One sub-module, `hazard_detect`, holds the combinational `lu` comparator. All state stays in `npc_ctrl`.

## Test plan
- Reset asserted mid MEM_STALL with `pend_valid=1` → outputs at reset values immediately; after release, `pend_valid=0` and `npc = pc + 4`.
- Sequential run with `pc=0x100` → `npc=0x104`, `pc_write_en=1`, no flushes.
- Load-use: `ex_memread=1`, `ex_rd=5`, `id_rs1=5`, `id_use_rs1=1` → exactly one cycle with `pc_write_en=0` and `idex_flush=1`, then `npc=pc+4`. The same stimulus with `ex_rd=0` → no stall.
- Redirect concurrent with `lu`, `ex_target=0x200` → `npc=0x200`, both flushes 1, no stall cycle.
- `dmem_busy` high for 3 cycles with an `ex_redirect` pulse (target `0x340`) in the 2nd cycle → 3 frozen cycles, then `npc=0x340` with flushes, and `pend_valid` cleared.
- `pc=0xFFFF_FFFC` → `npc=0`. With `NPC_CTRL_PERF_EN`: after the above sequence, `perf_mem_stalls=3` and `perf_redirects=2`.
